// File: rtl/comparator_seq.sv
// Wide equal/less-than compare resolved MSB-chunk-first on a shared CHUNK-bit
// combinational comparator, stopping at the first unequal chunk.
module comparator_seq #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sgnd,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Flags,
  output logic [CHUNK-1:0] CmpA,
  output logic [CHUNK-1:0] CmpB,
  output logic             CmpSgnd,
  input  logic [1:0]       CmpFlags
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = $clog2(NCHUNK);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_flags;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgnd;

  logic w_accept;
  logic w_eq;
  logic w_lt;

  // Start is only honoured outside RUN, and Flush vetoes it.
  assign w_accept = (r_state != S_RUN) && Start && !Flush;
  assign w_eq     = CmpFlags[1];
  assign w_lt     = CmpFlags[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_flags <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_idx   <= LAST;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (Flush) begin
            r_state <= S_IDLE;
          end else if (!w_eq) begin
            r_flags <= {1'b0, w_lt};
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            r_flags <= 2'b10;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand latches carry no reset; they are only observed while in RUN.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_a    <= A;
      r_b    <= B;
      r_sgnd <= Sgnd;
    end
  end

  always_comb begin
    CmpA    = '0;
    CmpB    = '0;
    CmpSgnd = 1'b0;
    if (r_state == S_RUN) begin
      CmpA    = r_a[r_idx*CHUNK +: CHUNK];
      CmpB    = r_b[r_idx*CHUNK +: CHUNK];
      // Only the top chunk carries the sign; lower chunks are magnitude bits.
      CmpSgnd = r_sgnd && (r_idx == LAST);
    end
  end

  assign Busy  = (r_state == S_RUN);
  assign Done  = (r_state == S_DONE);
  assign Flags = r_flags;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq with a behavioural shared comparator.
module tb_comparator_seq;

  localparam int WIDTH = 128;
  localparam int CHUNK = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Sgnd = 1'b0;
  logic             Flush = 1'b0;
  logic             Busy;
  logic             Done;
  logic [1:0]       Flags;
  logic [CHUNK-1:0] CmpA;
  logic [CHUNK-1:0] CmpB;
  logic             CmpSgnd;
  logic [1:0]       CmpFlags;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [WIDTH-1:0] EQV = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B), .Sgnd(Sgnd),
    .Flush(Flush), .Busy(Busy), .Done(Done), .Flags(Flags),
    .CmpA(CmpA), .CmpB(CmpB), .CmpSgnd(CmpSgnd), .CmpFlags(CmpFlags)
  );

  always #5 clk = ~clk;

  // Shared combinational comparator seen by the sequencer
  always_comb begin
    CmpFlags[1] = (CmpA == CmpB);
    CmpFlags[0] = CmpSgnd ? ($signed(CmpA) < $signed(CmpB)) : (CmpA < CmpB);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b1; A = '1; B = '0;
    step(); step();
    n_chk++; if ({Busy, Done, Flags} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {Busy, Done, Flags}); else n_pass++;
    n_chk++; if ({CmpA, CmpB, CmpSgnd} !== '0) $display("FAIL reset_cmp: got %h/%h/%b expected 0", CmpA, CmpB, CmpSgnd); else n_pass++;
    reset = 1'b0; Start = 1'b0;
    step();
    n_chk++; if (Busy !== 1'b0) $display("FAIL reset_idle: Busy got %b expected 0", Busy); else n_pass++;
  endtask

  task automatic test_signed_top();
    A = '1; B = '0; Sgnd = 1'b1; Start = 1'b1;
    step(); Start = 1'b0;
    n_chk++; if ({Busy, Done, CmpSgnd} !== 3'b101) $display("FAIL st_c1: Busy/Done/CmpSgnd got %b expected 101", {Busy, Done, CmpSgnd}); else n_pass++;
    n_chk++; if (CmpA !== 32'hFFFF_FFFF || CmpB !== 32'h0) $display("FAIL st_c1_data: got %h/%h expected ffffffff/00000000", CmpA, CmpB); else n_pass++;
    step();
    n_chk++; if ({Busy, Done, Flags} !== 4'b0101) $display("FAIL st_c2: Busy/Done/Flags got %b expected 0101", {Busy, Done, Flags}); else n_pass++;
    // same operands unsigned, started from the DONE cycle
    Sgnd = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    n_chk++; if ({Busy, CmpSgnd} !== 2'b10) $display("FAIL su_c1: Busy/CmpSgnd got %b expected 10", {Busy, CmpSgnd}); else n_pass++;
    step();
    n_chk++; if ({Done, Flags} !== 3'b100) $display("FAIL su_c2: Done/Flags got %b expected 100", {Done, Flags}); else n_pass++;
    step();
    n_chk++; if ({Busy, Done} !== 2'b00) $display("FAIL su_idle: Busy/Done got %b expected 00", {Busy, Done}); else n_pass++;
  endtask

  task automatic test_equal();
    logic [CHUNK-1:0] exp_a [4];
    exp_a[0] = 32'h0123_4567; exp_a[1] = 32'h89AB_CDEF;
    exp_a[2] = 32'h0011_2233; exp_a[3] = 32'h4455_6677;
    A = EQV; B = EQV; Sgnd = 1'b1; Start = 1'b1;
    step(); Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (CmpA !== exp_a[k] || CmpB !== exp_a[k] || Busy !== 1'b1 || Done !== 1'b0 || CmpSgnd !== (k == 0))
        $display("FAIL eq_c%0d: CmpA %h CmpB %h Busy %b Done %b Sg %b expected %h busy", k + 1, CmpA, CmpB, Busy, Done, CmpSgnd, exp_a[k]);
      else n_pass++;
      step();
    end
    n_chk++; if ({Busy, Done, Flags} !== 4'b0110) $display("FAIL eq_c5: Busy/Done/Flags got %b expected 0110", {Busy, Done, Flags}); else n_pass++;
    step();
    n_chk++; if ({Done, Flags} !== 3'b010) $display("FAIL eq_hold: Done/Flags got %b expected 010", {Done, Flags}); else n_pass++;
  endtask

  task automatic test_flush();
    A = EQV; B = EQV; Sgnd = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    step(); Flush = 1'b1;
    step(); Flush = 1'b0;
    n_chk++; if ({Busy, Done, Flags} !== 4'b0010) $display("FAIL flush_c3: Busy/Done/Flags got %b expected 0010", {Busy, Done, Flags}); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++; if (Done !== 1'b0 || Flags !== 2'b10) $display("FAIL flush_nodone%0d: Done/Flags got %b%b expected 010", k, Done, Flags); else n_pass++;
    end
  endtask

  task automatic test_low_chunk();
    A = {EQV[127:32], 32'hFFFF_FFFF}; B = {EQV[127:32], 32'h0000_0001}; Sgnd = 1'b1; Start = 1'b1;
    step(); Start = 1'b0;
    n_chk++; if (CmpSgnd !== 1'b1) $display("FAIL low_c1: CmpSgnd got %b expected 1", CmpSgnd); else n_pass++;
    step(); step(); step();
    n_chk++; if (CmpSgnd !== 1'b0 || CmpA !== 32'hFFFF_FFFF || CmpB !== 32'h1) $display("FAIL low_c4: Sg %b A %h B %h expected 0 ffffffff 00000001", CmpSgnd, CmpA, CmpB); else n_pass++;
    step();
    n_chk++; if ({Done, Flags} !== 3'b100) $display("FAIL low_c5: Done/Flags got %b expected 100", {Done, Flags}); else n_pass++;
    step();
  endtask

  task automatic test_mid_chunk();
    A = {EQV[127:64], 32'h8000_0000, 32'h0}; B = {EQV[127:64], 32'h0000_0001, 32'h0}; Sgnd = 1'b1; Start = 1'b1;
    Flags_pre: begin end
    step(); Start = 1'b0;
    step(); step();
    n_chk++; if ({Done, CmpSgnd} !== 2'b00 || CmpA !== 32'h8000_0000) $display("FAIL mid_c3: Done/Sg %b A %h expected 00 80000000", {Done, CmpSgnd}, CmpA); else n_pass++;
    step();
    n_chk++; if ({Done, Flags} !== 3'b100) $display("FAIL mid_c4: Done/Flags got %b expected 100", {Done, Flags}); else n_pass++;
    step();
  endtask

  task automatic test_start_held();
    A = EQV; B = EQV; Sgnd = 1'b0; Start = 1'b1;
    step();
    n_chk++; if (CmpA !== 32'h0123_4567) $display("FAIL held_c1: CmpA got %h expected 01234567", CmpA); else n_pass++;
    step();
    n_chk++; if (CmpA !== 32'h89AB_CDEF) $display("FAIL held_c2: CmpA got %h expected 89abcdef", CmpA); else n_pass++;
    step(); step(); Start = 1'b0;
    step();
    n_chk++; if ({Done, Flags} !== 3'b110) $display("FAIL held_c5: Done/Flags got %b expected 110", {Done, Flags}); else n_pass++;
    step();
  endtask

  task automatic test_flush_idle();
    A = '1; B = '0; Start = 1'b1; Flush = 1'b1;
    step(); Start = 1'b0; Flush = 1'b0;
    n_chk++; if ({Busy, Done} !== 2'b00) $display("FAIL flush_idle: Busy/Done got %b expected 00", {Busy, Done}); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    A = '1; B = '0; Sgnd = 1'b0; Start = 1'b1;
    step(); Start = 1'b0;
    step();
    n_chk++; if ({Done, Flags} !== 3'b100) $display("FAIL b2b_first: Done/Flags got %b expected 100", {Done, Flags}); else n_pass++;
    A = EQV; B = EQV; Start = 1'b1;
    step(); Start = 1'b0; A = '0; B = '1;
    n_chk++; if (Busy !== 1'b1 || Done !== 1'b0 || CmpA !== 32'h0123_4567) $display("FAIL b2b_run: Busy %b Done %b A %h expected 1 0 01234567", Busy, Done, CmpA); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if (Done !== 1'b0) $display("FAIL b2b_early%0d: Done got %b expected 0", k, Done); else n_pass++;
    end
    step();
    n_chk++; if ({Done, Flags} !== 3'b110) $display("FAIL b2b_second: Done/Flags got %b expected 110", {Done, Flags}); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_run();
    A = EQV; B = EQV; Start = 1'b1;
    step(); Start = 1'b0;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    n_chk++; if ({Busy, Done, Flags} !== 4'b0000 || CmpA !== 32'h0) $display("FAIL rst_mid: Busy/Done/Flags %b A %h expected 0000 0", {Busy, Done, Flags}, CmpA); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++; if ({Busy, Done} !== 2'b00) $display("FAIL rst_nodone%0d: Busy/Done got %b expected 00", k, {Busy, Done}); else n_pass++;
    end
  endtask

  initial begin
    step();
    test_reset();
    test_signed_top();
    test_equal();
    test_flush();
    test_low_chunk();
    test_mid_chunk();
    test_start_held();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
